// File: rtl/pp_sdio_pkg.sv
// Shared definitions for the SDIO host data-path counters: state encoding,
// CRC/end-bit gap lengths and the gap-timer preset helper.
package pp_sdio_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DATA = ST_DATA,
    S_GAP  = ST_GAP
  } state_t;

  // 16 CRC bits plus the end bit; in 4-bit mode each DAT line carries its
  // own CRC16 in parallel, so the gap length is the same.
  localparam int GAP_DEFAULT = 17;
  localparam int GAP_CRC1    = 17;
  localparam int GAP_CRC4    = 17;

  function automatic logic [7:0] gap_preset(input int gap);
    return 8'(gap - 1);
  endfunction

endpackage

// File: rtl/pp_blkcnt_rx_if.sv
// Control/status bundle between the SDIO host FSM and the receive block counter.
interface pp_blkcnt_rx_if #(
  parameter int WIDTH = 8,
  parameter int BLKW  = 8
);
  logic             START;
  logic             ABORT;
  logic [WIDTH-1:0] BLKSIZE;
  logic [BLKW-1:0]  BLKCNT;
  logic             BYTE_EN;
  logic [WIDTH-1:0] BYTE_Q;
  logic [BLKW-1:0]  BLK_Q;
  logic             BUSY;
  logic             BLK_END;
  logic             DONE;

  modport master (
    output START, ABORT, BLKSIZE, BLKCNT, BYTE_EN,
    input  BYTE_Q, BLK_Q, BUSY, BLK_END, DONE
  );

  modport slave (
    input  START, ABORT, BLKSIZE, BLKCNT, BYTE_EN,
    output BYTE_Q, BLK_Q, BUSY, BLK_END, DONE
  );
endinterface

// File: rtl/pp_dcntx8.sv
// 8-bit loadable down-counter; LOAD wins over EN and the count parks at zero.
module pp_dcntx8 (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic       EN,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      Q <= 8'd0;
    end else if (LOAD) begin
      Q <= D;
    end else if (EN && (Q != 8'd0)) begin
      Q <= Q - 8'd1;
    end
  end

endmodule

// File: rtl/pp_blkcnt_rx.sv
// Receive-side byte/block progress tracker: counts bytes up to the block size,
// blocks up to the block count, and holds off for the CRC/end-bit gap after each block.
module pp_blkcnt_rx
  import pp_sdio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BLKW  = 8,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic               CLK,
  input  logic               CLR,
  pp_blkcnt_rx_if.slave      bus
);

  localparam logic [7:0] GAP_LOAD = gap_preset(GAP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] size_r, byte_q, byte_nxt;
  logic [BLKW-1:0]  cnt_r, blk_q, blk_nxt;
  logic             busy_q, blk_end_q, done_q;
  logic             blk_end_nxt, done_nxt, latch;
  logic             gap_load, gap_en, gap_zero, last_byte;
  logic [7:0]       gap_q;

  pp_dcntx8 u_gap (
    .CLK  (CLK),
    .CLR  (CLR),
    .LOAD (gap_load),
    .EN   (gap_en),
    .D    (GAP_LOAD),
    .Q    (gap_q)
  );

  assign gap_zero  = (gap_q == 8'd0);
  assign gap_en    = (state == S_GAP);
  // A latched size of 0 makes size-1 all ones, giving a full 2^WIDTH block.
  assign last_byte = (byte_q == size_r - 1'b1);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    byte_nxt    = byte_q;
    blk_nxt     = blk_q;
    blk_end_nxt = 1'b0;
    done_nxt    = 1'b0;
    latch       = 1'b0;
    gap_load    = 1'b0;
    if (bus.ABORT) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            byte_nxt = '0;
            blk_nxt  = '0;
            if (bus.BLKCNT != '0) begin
              latch     = 1'b1;
              state_nxt = S_DATA;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        S_DATA: begin
          if (bus.BYTE_EN) begin
            if (last_byte) begin
              byte_nxt    = '0;
              blk_nxt     = blk_q + 1'b1;
              blk_end_nxt = 1'b1;
              gap_load    = 1'b1;
              state_nxt   = S_GAP;
            end else begin
              byte_nxt = byte_q + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            if (blk_q == cnt_r) begin
              done_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DATA;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      size_r    <= '0;
      cnt_r     <= '0;
      byte_q    <= '0;
      blk_q     <= '0;
      busy_q    <= 1'b0;
      blk_end_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (latch) begin
        size_r <= bus.BLKSIZE;
        cnt_r  <= bus.BLKCNT;
      end
      byte_q    <= byte_nxt;
      blk_q     <= blk_nxt;
      busy_q    <= (state_nxt != S_IDLE);
      blk_end_q <= blk_end_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.BYTE_Q  = byte_q;
  assign bus.BLK_Q   = blk_q;
  assign bus.BUSY    = busy_q;
  assign bus.BLK_END = blk_end_q;
  assign bus.DONE    = done_q;

endmodule
